// File: rtl/joy_poll_sched.sv
// Round-robin poll scheduler sharing one SPI master between two joysticks; decodes frames, emits cursor ticks.
// Optional WAIT watchdog with sticky per-player error flags is enabled by defining JOY_TIMEOUT_EN.
module joy_poll_sched #(
    parameter int unsigned POLL_DIV    = 250000,
    parameter int unsigned UPD_ROUNDS  = 4
`ifdef JOY_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 50000
`endif
) (
    input  logic        clk_i,
    input  logic        clr_i,
    output logic        spi_start_o,
    output logic        spi_sel_o,
    input  logic        spi_busy_i,
    input  logic        spi_done_i,
    input  logic [39:0] spi_rx_i,
    output logic [9:0]  joy1_x_o,
    output logic [9:0]  joy1_y_o,
    output logic [9:0]  joy2_x_o,
    output logic [9:0]  joy2_y_o,
    output logic [2:0]  joy1_btn_o,
    output logic [2:0]  joy2_btn_o,
    output logic        cursor_tick_o,
    output logic [1:0]  err_o
);

    localparam int unsigned SLOT_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
    localparam int unsigned RND_W  = (UPD_ROUNDS > 1) ? $clog2(UPD_ROUNDS) : 1;
    localparam int unsigned AX_W   = 10;
    localparam int unsigned BTN_W  = 3;
    localparam logic [AX_W-1:0] AX_CENTRE = AX_W'(512);

    typedef enum logic [1:0] {IDLE, START, WAIT, LATCH} state_e;

    state_e            state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [RND_W-1:0]  round_q, round_d;
    logic              pending_q, pending_d;
    logic              sel_q, sel_d;
    logic              start_q, start_d;
    logic              tick_q, tick_d;
    logic [AX_W-1:0]   fx_q, fx_d, fy_q, fy_d;
    logic [BTN_W-1:0]  fb_q, fb_d;
    logic [AX_W-1:0]   j1x_q, j1x_d, j1y_q, j1y_d, j2x_q, j2x_d, j2y_q, j2y_d;
    logic [BTN_W-1:0]  j1b_q, j1b_d, j2b_q, j2b_d;
    logic              slot_wrap;
    logic              round_evt;
    logic              rx_unused;

`ifdef JOY_TIMEOUT_EN
    localparam int unsigned WT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [WT_W-1:0]   wt_q, wt_d;
    logic [1:0]        err_q, err_d;
`endif

    // Frame bits that carry no joystick data.
    assign rx_unused = ^{spi_rx_i[31:26], spi_rx_i[15:10], spi_rx_i[7:3]};

    // Next-state: slot pacing, poll FSM, frame capture/latch and round counting.
    always_comb begin
        state_d   = state_q;
        slot_wrap = (slot_q == SLOT_W'(POLL_DIV - 1));
        slot_d    = slot_wrap ? '0 : slot_q + 1'b1;
        pending_d = pending_q;
        sel_d     = sel_q;
        tick_d    = 1'b0;
        round_d   = round_q;
        round_evt = 1'b0;
        fx_d      = fx_q;
        fy_d      = fy_q;
        fb_d      = fb_q;
        j1x_d     = j1x_q;
        j1y_d     = j1y_q;
        j1b_d     = j1b_q;
        j2x_d     = j2x_q;
        j2y_d     = j2y_q;
        j2b_d     = j2b_q;
`ifdef JOY_TIMEOUT_EN
        wt_d      = wt_q;
        err_d     = err_q;
`endif
        case (state_q)
            IDLE: begin
                if ((pending_q || slot_wrap) && !spi_busy_i) begin
                    state_d = START;
                end
            end
            START: begin
                pending_d = 1'b0;
                state_d   = WAIT;
`ifdef JOY_TIMEOUT_EN
                wt_d      = '0;
`endif
            end
            WAIT: begin
                if (spi_done_i) begin
                    fx_d    = {spi_rx_i[25:24], spi_rx_i[39:32]};
                    fy_d    = {spi_rx_i[9:8], spi_rx_i[23:16]};
                    fb_d    = spi_rx_i[2:0];
                    state_d = LATCH;
                end
`ifdef JOY_TIMEOUT_EN
                else if (wt_q == WT_W'(TIMEOUT_CYC - 1)) begin
                    // Silent player: keep its old values, flag it and move on as if latched.
                    err_d[sel_q] = 1'b1;
                    sel_d        = ~sel_q;
                    round_evt    = 1'b1;
                    state_d      = IDLE;
                end else begin
                    wt_d = wt_q + 1'b1;
                end
`endif
            end
            LATCH: begin
                if (sel_q) begin
                    j2x_d = fx_q;
                    j2y_d = fy_q;
                    j2b_d = fb_q;
                end else begin
                    j1x_d = fx_q;
                    j1y_d = fy_q;
                    j1b_d = fb_q;
                end
                sel_d     = ~sel_q;
                round_evt = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A wrap while a poll is still owed is absorbed by the single flag.
        if (slot_wrap) begin
            pending_d = 1'b1;
        end
        if (round_evt && sel_q) begin
            if (round_q == RND_W'(UPD_ROUNDS - 1)) begin
                round_d = '0;
                tick_d  = 1'b1;
            end else begin
                round_d = round_q + 1'b1;
            end
        end
        start_d = (state_d == START);
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            state_q   <= IDLE;
            slot_q    <= '0;
            round_q   <= '0;
            pending_q <= 1'b0;
            sel_q     <= 1'b0;
            start_q   <= 1'b0;
            tick_q    <= 1'b0;
            fx_q      <= '0;
            fy_q      <= '0;
            fb_q      <= '0;
            j1x_q     <= AX_CENTRE;
            j1y_q     <= AX_CENTRE;
            j2x_q     <= AX_CENTRE;
            j2y_q     <= AX_CENTRE;
            j1b_q     <= '0;
            j2b_q     <= '0;
`ifdef JOY_TIMEOUT_EN
            wt_q      <= '0;
            err_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            round_q   <= round_d;
            pending_q <= pending_d;
            sel_q     <= sel_d;
            start_q   <= start_d;
            tick_q    <= tick_d;
            fx_q      <= fx_d;
            fy_q      <= fy_d;
            fb_q      <= fb_d;
            j1x_q     <= j1x_d;
            j1y_q     <= j1y_d;
            j2x_q     <= j2x_d;
            j2y_q     <= j2y_d;
            j1b_q     <= j1b_d;
            j2b_q     <= j2b_d;
`ifdef JOY_TIMEOUT_EN
            wt_q      <= wt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign spi_start_o   = start_q;
    assign spi_sel_o     = sel_q;
    assign cursor_tick_o = tick_q;
    assign joy1_x_o      = j1x_q;
    assign joy1_y_o      = j1y_q;
    assign joy2_x_o      = j2x_q;
    assign joy2_y_o      = j2y_q;
    assign joy1_btn_o    = j1b_q;
    assign joy2_btn_o    = j2b_q;
`ifdef JOY_TIMEOUT_EN
    assign err_o         = err_q;
`else
    assign err_o         = 2'b00;
`endif

endmodule

// File: tb/tb_joy_poll_sched.sv
// Self-checking bench for joy_poll_sched: directed steps plus randomized frames against a transaction-level model.
`timescale 1ns/1ps
module tb_joy_poll_sched;

    localparam int POLL_DIV    = 10;
    localparam int UPD_ROUNDS  = 2;
    localparam int LPT         = 2 * UPD_ROUNDS;
`ifdef JOY_TIMEOUT_EN
    localparam int TIMEOUT_CYC = 20;
`endif

    logic        clk = 1'b0;
    logic        clr;
    logic        spi_start, spi_sel, spi_busy, spi_done;
    logic [39:0] spi_rx;
    logic [9:0]  j1x, j1y, j2x, j2y;
    logic [2:0]  j1b, j2b;
    logic        ctick;
    logic [1:0]  err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int latches = 0;
    int exp_start = 0;
    logic exp_sel;
    logic [9:0] mx [2];
    logic [9:0] my [2];
    logic [2:0] mb [2];

    always #5 clk = ~clk;

    joy_poll_sched #(
        .POLL_DIV(POLL_DIV),
        .UPD_ROUNDS(UPD_ROUNDS)
`ifdef JOY_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(TIMEOUT_CYC)
`endif
    ) dut (
        .clk_i(clk),
        .clr_i(clr),
        .spi_start_o(spi_start),
        .spi_sel_o(spi_sel),
        .spi_busy_i(spi_busy),
        .spi_done_i(spi_done),
        .spi_rx_i(spi_rx),
        .joy1_x_o(j1x),
        .joy1_y_o(j1y),
        .joy2_x_o(j2x),
        .joy2_y_o(j2y),
        .joy1_btn_o(j1b),
        .joy2_btn_o(j2b),
        .cursor_tick_o(ctick),
        .err_o(err)
    );

    function automatic logic [9:0] ref_x(input logic [39:0] f);
        return 10'(((f >> 24) % 4) * 256 + ((f >> 32) % 256));
    endfunction

    function automatic logic [9:0] ref_y(input logic [39:0] f);
        return 10'(((f >> 8) % 4) * 256 + ((f >> 16) % 256));
    endfunction

    function automatic logic [2:0] ref_b(input logic [39:0] f);
        return 3'(f % 8);
    endfunction

    function automatic logic [39:0] rnd40();
        return {8'($urandom), $urandom};
    endfunction

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, expv, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            mx[p] = 10'd512;
            my[p] = 10'd512;
            mb[p] = 3'd0;
        end
        exp_sel   = 1'b0;
        latches   = 0;
        exp_start = POLL_DIV;
    endtask

    task automatic check_joy(input string tag);
        chk({tag, "_j1x"}, 40'(j1x), 40'(mx[0]));
        chk({tag, "_j1y"}, 40'(j1y), 40'(my[0]));
        chk({tag, "_j1b"}, 40'(j1b), 40'(mb[0]));
        chk({tag, "_j2x"}, 40'(j2x), 40'(mx[1]));
        chk({tag, "_j2y"}, 40'(j2y), 40'(my[1]));
        chk({tag, "_j2b"}, 40'(j2b), 40'(mb[1]));
    endtask

    task automatic check_reset(input string tag);
        check_joy(tag);
        chk({tag, "_start"}, 40'(spi_start), 40'd0);
        chk({tag, "_sel"},   40'(spi_sel),   40'd0);
        chk({tag, "_tick"},  40'(ctick),     40'd0);
        chk({tag, "_err"},   40'(err),       40'd0);
    endtask

    // Returns the cycle in which spi_start is high, checking the current cycle first.
    task automatic wait_start(output int sc);
        sc = -1;
        for (int i = 0; i < 200; i++) begin
            if (spi_start === 1'b1) begin
                sc = cyc;
                break;
            end
            step();
        end
        chk("start_seen", 40'(sc >= 0), 40'd1);
    endtask

    // Serves one poll whose START is the current cycle; answers lat cycles later.
    task automatic txn(input int lat, input logic [39:0] fr, input int sc);
        int p;
        int d;
        int w;
        p = exp_sel ? 1 : 0;
        chk("start_sel", 40'(spi_sel), 40'(exp_sel));
        if (exp_start >= 0) chk("start_cycle", 40'(sc), 40'(exp_start));
        step();
        chk("start_width", 40'(spi_start), 40'd0);
        repeat (lat - 1) step();
        chk("sel_stable", 40'(spi_sel), 40'(exp_sel));
        spi_done = 1'b1;
        spi_rx   = fr;
        step();
        spi_done = 1'b0;
        spi_rx   = rnd40();
        check_joy("latch_hold");
        chk("tick_early", 40'(ctick), 40'd0);
        step();
        mx[p] = ref_x(fr);
        my[p] = ref_y(fr);
        mb[p] = ref_b(fr);
        latches++;
        check_joy("decode");
        chk("cursor_tick", 40'(ctick), 40'((latches % LPT) == 0));
        exp_sel = ~exp_sel;
        // Next poll: right away if a slot wrapped while busy, else one cycle after the next wrap.
        d = sc + lat;
        w = sc + 1;
        while ((w % POLL_DIV) != POLL_DIV - 1) w++;
        exp_start = (w <= d + 2) ? d + 3 : w + 1;
        step();
        chk("tick_width", 40'(ctick), 40'd0);
    endtask

    initial begin
        int sc;
        int lat;
        int nstart;
        int nticks;
        int rel;
        logic [39:0] fr;

        clr      = 1'b1;
        spi_busy = 1'b0;
        spi_done = 1'b0;
        spi_rx   = '0;
        repeat (3) @(negedge clk);
        model_reset();
        check_reset("rst");
        clr = 1'b0;
        cyc = 0;

        // Directed first poll with the reference frame.
        wait_start(sc);
        txn(5, 40'h2C01F00207, sc);
        chk("dir_j1x", 40'(j1x), 40'd300);
        chk("dir_j1y", 40'(j1y), 40'd752);
        chk("dir_j1b", 40'(j1b), 40'd7);

        // Randomized frames and latencies, with stray spi_done pulses while idle.
        for (int t = 0; t < 16; t++) begin
            wait_start(sc);
            lat = 1 + int'($urandom_range(4));
            txn(lat, rnd40(), sc);
            if (lat <= 3 && exp_start > cyc + 2 && ($urandom % 2) == 1) begin
                spi_done = 1'b1;
                spi_rx   = rnd40();
                step();
                spi_done = 1'b0;
                step();
                check_joy("stray_done");
            end
        end

        // Busy hold-off across several slot wraps.
        spi_busy = 1'b1;
        nstart   = 0;
        for (int i = 0; i < 3 * POLL_DIV + 2; i++) begin
            step();
            if (spi_start === 1'b1) nstart++;
        end
        while ((cyc % POLL_DIV) != 1) begin
            step();
            if (spi_start === 1'b1) nstart++;
        end
        chk("busy_hold", 40'(nstart), 40'd0);
        spi_busy = 1'b0;
        rel = cyc;
        step();
        chk("busy_release_start", 40'(spi_start), 40'd1);
        exp_start = -1;
        txn(3, rnd40(), rel + 1);
        wait_start(sc);
        txn(2, rnd40(), sc);

        // Reset in the middle of WAIT, followed by a late response.
        wait_start(sc);
        step();
        step();
        clr = 1'b1;
        step();
        step();
        model_reset();
        check_reset("midwait_rst");
        clr = 1'b0;
        cyc = 0;
        spi_done = 1'b1;
        spi_rx   = rnd40();
        step();
        spi_done = 1'b0;
        nticks   = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (ctick === 1'b1) nticks++;
        end
        chk("late_done_tick", 40'(nticks), 40'd0);
        check_joy("late_done");
        for (int t = 0; t < 5; t++) begin
            wait_start(sc);
            txn(1 + int'($urandom_range(4)), rnd40(), sc);
        end

`ifdef JOY_TIMEOUT_EN
        if (exp_sel == 1'b0) begin
            wait_start(sc);
            txn(2, rnd40(), sc);
        end
        // P2 answers on the last WAIT cycle: the response wins over the watchdog.
        wait_start(sc);
        txn(TIMEOUT_CYC, rnd40(), sc);
        chk("done_beats_timeout", 40'(err), 40'd0);
        wait_start(sc);
        txn(2, rnd40(), sc);
        // P2 stays silent.
        wait_start(sc);
        chk("to_start_cycle", 40'(sc), 40'(exp_start));
        chk("to_sel", 40'(spi_sel), 40'd1);
        repeat (TIMEOUT_CYC) step();
        chk("to_err_pre", 40'(err), 40'd0);
        chk("to_sel_hold", 40'(spi_sel), 40'd1);
        step();
        chk("to_err", 40'(err), 40'b10);
        check_joy("to_keep");
        chk("to_sel_next", 40'(spi_sel), 40'd0);
        latches++;
        chk("to_tick", 40'(ctick), 40'((latches % LPT) == 0));
        exp_sel   = 1'b0;
        exp_start = sc + TIMEOUT_CYC + 2;
        step();
        chk("to_tick_width", 40'(ctick), 40'd0);
        wait_start(sc);
        fr = rnd40();
        txn(3, fr, sc);
        chk("err_sticky", 40'(err), 40'b10);
`else
        chk("err_tied", 40'(err), 40'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "simulation time limit reached");
    end

endmodule
